exm_sequencer: RTL and testbench
================================

Name: exm_sequencer

Overview:
Multi-cycle controller for the execute-memory stage. It sequences the two-word PC push/pop used by CALL, RET and RTI, and the three-cycle hardware interrupt entry.
It drives the stack, PC and flag steering controls of the stage, plus a stall to the front end.
It sits beside the decode/EX buffer and replaces the per-instruction stack control bits whenever a sequence is active.

Parameters:
INT_VECTOR_ADDR, 16'h0000, data-memory address holding the interrupt handler low PC word
STATE_W, 3, width of the state encoding exported on o_state

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  reset, asynchronous, active-low (0 = reset)
i_call  in  1  CALL decoded and valid in EX this cycle
i_ret  in  1  RET decoded and valid in EX this cycle
i_rti  in  1  RTI decoded and valid in EX this cycle
i_int  in  1  external interrupt request, level or pulse, sampled each edge
o_hazard_state  out  1  0 = first word of sequence, 1 = second word
o_stall  out  1  freeze PC, fetch/decode and the decode/EX buffer
o_stack_operation  out  1  stack pointer update enable
o_stack_function  out  1  1 push, 0 pop
o_push_pc  out  1  memory write data is a PC word
o_pop_pc  out  1  memory read data is a PC word
o_branch_flags  out  1  flags travel with the PC (interrupt push, RTI pop)
o_mem_read  out  1  data memory read
o_mem_write  out  1  data memory write
o_vector_sel  out  1  memory address forced to INT_VECTOR_ADDR
o_int_ack  out  1  one-cycle pulse when the interrupt sequence starts
o_busy  out  1  state != IDLE
o_state  out  STATE_W  current state, for debug and verification

Behaviour:
- States: IDLE, PUSH2, POP2, INT1, INT2, INTV. Encoding is fixed in the package.
- Reset (i_reset=0, asynchronous):
  - state is IDLE; pending, in_isr and all outputs are 0.
  - Reset asserted mid-sequence aborts it; no partial recovery.
- IDLE with i_call (first cycle is combinational from the inputs):
  - Asserts o_stack_operation=1, o_stack_function=1, o_push_pc=1, o_mem_write=1, o_hazard_state=0; this pushes the PC high word.
  - o_stall=1; next state is PUSH2.
- PUSH2: same push controls with o_hazard_state=1, pushing the PC low word. o_stall=0; next state is IDLE.
- IDLE with i_ret or i_rti:
  - Asserts o_stack_operation=1, o_stack_function=0, o_pop_pc=1, o_mem_read=1, o_hazard_state=0; this pops the low word into the PC temp register.
  - o_branch_flags=i_rti. o_stall=1; next state is POP2.
- POP2:
  - Pop controls with o_hazard_state=1: the high word loads the new PC, and for RTI also restores the flags.
  - o_branch_flags holds the registered RTI bit. Next state is IDLE.
  - If RTI, in_isr clears at this edge.
- Only one of i_call, i_ret, i_rti may be high in a cycle. Priority if violated: call > rti > ret. The bench flags a violation as an error.
- Inputs i_call, i_ret and i_rti are ignored outside IDLE; the front end is stalled, so they are stale.
- Interrupt handling:
  - pending sets on any edge with i_int=1 and holds until the interrupt sequence is taken; repeated requests merge into one.
  - Taken in IDLE when pending=1, in_isr=0 and no instruction sequence starts that cycle; instructions have priority.
  - Taking it: o_int_ack=1, pending clears, in_isr sets, next state is INT1.
- INT1: push high word with o_branch_flags=1, o_hazard_state=0, o_stall=1.
- INT2: push low word with o_branch_flags=0, o_hazard_state=1, o_stall=1.
- INTV:
  - o_vector_sel=1, o_mem_read=1, o_pop_pc=1, o_hazard_state=0, o_stall=1. The memory word loads the PC temp register.
  - Next state is POP2 with o_branch_flags=0; the high word comes from INT_VECTOR_ADDR+1 via o_vector_sel, which stays 1 in POP2-from-INTV.
- Requests arriving while in_isr=1 stay pending and are taken on the first IDLE cycle after RTI completes.
- Latencies: CALL 2 cycles, RET/RTI 2 cycles, interrupt 5 cycles (ack cycle plus INT1, INT2, INTV, POP2).
- Stack pointer arithmetic stays in the stack pointer block. This block only gates its enable and direction.

Decomposition:
- Shared package exm_seq_pkg holds:
  - state localparams (IDLE=0, PUSH2=1, POP2=2, INT1=3, INT2=4, INTV=5)
  - the STATE_W default
  - the push/pop function constants (PUSH=1, POP=0)
- One sub-module, int_pending_latch: the pending and in_isr flops with set, clear and merge logic. It is reused by a future NMI path.

Test Plan:
- CALL in IDLE:
  - cycle0: push_pc=1, hazard=0, stall=1.
  - cycle1: push_pc=1, hazard=1, stall=0.
  - cycle2: state=IDLE, all controls 0.
- RTI in IDLE:
  - cycle0: pop_pc=1, branch_flags=1, hazard=0.
  - cycle1: pop_pc=1, branch_flags=1, hazard=1.
  - in_isr falls after cycle1.
- i_int pulse and i_call in the same cycle: CALL runs for 2 cycles, then o_int_ack pulses. States then run INT1→INT2→INTV→POP2→IDLE with stall=1 through INTV.
- Nested interrupt:
  - i_int during the handler (in_isr=1): no o_int_ack until RTI's POP2 completes.
  - Then o_int_ack fires on the next IDLE cycle; three i_int pulses yield exactly one ack.
- i_reset=0 asynchronously during INT2:
  - all outputs 0 immediately, o_state=IDLE, pending=0.
  - after release, a new CALL sequences normally.
- INTV cycle with INT_VECTOR_ADDR=16'h0000: o_vector_sel=1, mem_read=1, hazard=0.
  - Next cycle: vector_sel=1, hazard=1.

Source files
------------

// File: rtl/exm_seq_pkg.sv
// Shared types and constants for the execute-memory stage sequencer.
// State encoding, push/pop direction and the steering-control bundle.
package exm_seq_pkg;

    localparam int STATE_W_DEF = 3;

    localparam logic PUSH = 1'b1;
    localparam logic POP  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PUSH2 = 3'd1,
        ST_POP2  = 3'd2,
        ST_INT1  = 3'd3,
        ST_INT2  = 3'd4,
        ST_INTV  = 3'd5
    } state_e;

    typedef struct packed {
        logic hz;
        logic stall;
        logic sop;
        logic sfn;
        logic push;
        logic pop;
        logic bf;
        logic mr;
        logic mw;
        logic vsel;
        logic ack;
    } ctl_t;

endpackage

// File: rtl/exm_sequencer_int_pending_latch.sv
// Interrupt pending/in-service flops: requests merge into one pending bit,
// in_isr masks further entries until the matching RTI completes.
module int_pending_latch (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic set_i,
    input  logic take_i,
    input  logic done_i,
    output logic pending_o,
    output logic in_isr_o
);

    logic pending_q, pending_d;
    logic in_isr_q, in_isr_d;

    // A request arriving on the take edge is merged into the one being taken.
    always_comb begin
        pending_d = take_i ? 1'b0 : (pending_q | set_i);
        in_isr_d  = in_isr_q;
        if (take_i) begin
            in_isr_d = 1'b1;
        end else if (done_i) begin
            in_isr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= 1'b0;
            in_isr_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            in_isr_q  <= in_isr_d;
        end
    end

    assign pending_o = pending_q;
    assign in_isr_o  = in_isr_q;

endmodule

// File: rtl/exm_sequencer.sv
// Execute-memory multi-cycle controller: two-word PC push/pop for
// CALL/RET/RTI and the interrupt entry (push PC+flags, fetch vector).
module exm_sequencer
    import exm_seq_pkg::*;
#(
    parameter logic [15:0] INT_VECTOR_ADDR = 16'h0000,
    parameter int          STATE_W         = STATE_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_call,
    input  logic               i_ret,
    input  logic               i_rti,
    input  logic               i_int,
    output logic               o_hazard_state,
    output logic               o_stall,
    output logic               o_stack_operation,
    output logic               o_stack_function,
    output logic               o_push_pc,
    output logic               o_pop_pc,
    output logic               o_branch_flags,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_vector_sel,
    output logic               o_int_ack,
    output logic               o_busy,
    output logic [STATE_W-1:0] o_state
);

    if (STATE_W < 3) begin : g_bad_state_w
        $error("exm_sequencer: STATE_W must be at least 3");
    end
    if (INT_VECTOR_ADDR == 16'hFFFF) begin : g_bad_vector
        $error("exm_sequencer: vector high word would wrap");
    end

    state_e state_q, state_d;
    logic   rti_q, rti_d;
    logic   vec_q, vec_d;
    logic   pending, in_isr;
    logic   take, isr_done;
    ctl_t   ctl;

    always_comb begin
        ctl     = '0;
        state_d = state_q;
        rti_d   = rti_q;
        vec_d   = vec_q;
        take    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                rti_d = 1'b0;
                vec_d = 1'b0;
                if (i_call) begin
                    ctl.sop   = 1'b1;
                    ctl.sfn   = PUSH;
                    ctl.push  = 1'b1;
                    ctl.mw    = 1'b1;
                    ctl.stall = 1'b1;
                    state_d   = ST_PUSH2;
                end else if (i_rti || i_ret) begin
                    ctl.sop   = 1'b1;
                    ctl.sfn   = POP;
                    ctl.pop   = 1'b1;
                    ctl.mr    = 1'b1;
                    ctl.bf    = i_rti;
                    ctl.stall = 1'b1;
                    rti_d     = i_rti;
                    state_d   = ST_POP2;
                end else if (pending && !in_isr) begin
                    take      = 1'b1;
                    ctl.ack   = 1'b1;
                    ctl.stall = 1'b1;
                    state_d   = ST_INT1;
                end
            end
            ST_PUSH2: begin
                ctl.sop  = 1'b1;
                ctl.sfn  = PUSH;
                ctl.push = 1'b1;
                ctl.mw   = 1'b1;
                ctl.hz   = 1'b1;
                state_d  = ST_IDLE;
            end
            // After INTV the second word is a vector fetch, not a stack pop.
            ST_POP2: begin
                ctl.sop  = ~vec_q;
                ctl.sfn  = POP;
                ctl.pop  = 1'b1;
                ctl.mr   = 1'b1;
                ctl.hz   = 1'b1;
                ctl.bf   = rti_q;
                ctl.vsel = vec_q;
                state_d  = ST_IDLE;
            end
            ST_INT1: begin
                ctl.sop   = 1'b1;
                ctl.sfn   = PUSH;
                ctl.push  = 1'b1;
                ctl.mw    = 1'b1;
                ctl.bf    = 1'b1;
                ctl.stall = 1'b1;
                state_d   = ST_INT2;
            end
            ST_INT2: begin
                ctl.sop   = 1'b1;
                ctl.sfn   = PUSH;
                ctl.push  = 1'b1;
                ctl.mw    = 1'b1;
                ctl.hz    = 1'b1;
                ctl.stall = 1'b1;
                state_d   = ST_INTV;
            end
            ST_INTV: begin
                ctl.vsel  = 1'b1;
                ctl.mr    = 1'b1;
                ctl.pop   = 1'b1;
                ctl.stall = 1'b1;
                rti_d     = 1'b0;
                vec_d     = 1'b1;
                state_d   = ST_POP2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign isr_done = (state_q == ST_POP2) && rti_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            rti_q   <= 1'b0;
            vec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rti_q   <= rti_d;
            vec_q   <= vec_d;
        end
    end

    int_pending_latch u_pend (
        .clk_i    (i_clk),
        .rst_ni   (i_reset),
        .set_i    (i_int),
        .take_i   (take),
        .done_i   (isr_done),
        .pending_o(pending),
        .in_isr_o (in_isr)
    );

    // IDLE controls follow the inputs, so reset must mask them directly.
    assign o_hazard_state    = i_reset & ctl.hz;
    assign o_stall           = i_reset & ctl.stall;
    assign o_stack_operation = i_reset & ctl.sop;
    assign o_stack_function  = i_reset & ctl.sfn;
    assign o_push_pc         = i_reset & ctl.push;
    assign o_pop_pc          = i_reset & ctl.pop;
    assign o_branch_flags    = i_reset & ctl.bf;
    assign o_mem_read        = i_reset & ctl.mr;
    assign o_mem_write       = i_reset & ctl.mw;
    assign o_vector_sel      = i_reset & ctl.vsel;
    assign o_int_ack         = i_reset & ctl.ack;
    assign o_busy            = (state_q != ST_IDLE);
    assign o_state           = STATE_W'(state_q);

endmodule

// File: tb/tb_exm_sequencer.sv
// Bench for exm_sequencer: sequence-level reference model checked every
// cycle, plus directed literal checks on the key cycles.
module tb_exm_sequencer;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_call = 1'b0;
    logic       i_ret = 1'b0;
    logic       i_rti = 1'b0;
    logic       i_int = 1'b0;
    logic       o_hazard_state, o_stall, o_stack_operation;
    logic       o_stack_function, o_push_pc, o_pop_pc;
    logic       o_branch_flags, o_mem_read, o_mem_write;
    logic       o_vector_sel, o_int_ack, o_busy;
    logic [2:0] o_state;

    int asserts = 0;
    int fails = 0;
    int acks;

    always #5 i_clk = ~i_clk;

    exm_sequencer dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_call           (i_call),
        .i_ret            (i_ret),
        .i_rti            (i_rti),
        .i_int            (i_int),
        .o_hazard_state   (o_hazard_state),
        .o_stall          (o_stall),
        .o_stack_operation(o_stack_operation),
        .o_stack_function (o_stack_function),
        .o_push_pc        (o_push_pc),
        .o_pop_pc         (o_pop_pc),
        .o_branch_flags   (o_branch_flags),
        .o_mem_read       (o_mem_read),
        .o_mem_write      (o_mem_write),
        .o_vector_sel     (o_vector_sel),
        .o_int_ack        (o_int_ack),
        .o_busy           (o_busy),
        .o_state          (o_state)
    );

    typedef struct packed {
        logic [2:0] st;
        logic busy, ack, vsel, mw, mr, bf, pop, push, sfn, sop, stall, hz;
    } ev_t;

    function automatic ev_t v(input logic [2:0] st,
                              input logic hz, stall, sop, sfn, push, pop,
                              input logic bf, mr, mw, vsel, ack);
        ev_t e;
        e.st = st; e.busy = (st != 3'd0); e.ack = ack; e.vsel = vsel;
        e.mw = mw; e.mr = mr; e.bf = bf; e.pop = pop; e.push = push;
        e.sfn = sfn; e.sop = sop; e.stall = stall; e.hz = hz;
        return e;
    endfunction

    ev_t q[$];
    bit  qr[$];
    bit  pend = 1'b0;
    bit  isr = 1'b0;

    // Reference model: each started sequence enqueues its remaining cycles.
    always @(negedge i_clk) begin
        ev_t got, want;
        bit  endrti;
        got = {o_state, o_busy, o_int_ack, o_vector_sel, o_mem_write,
               o_mem_read, o_branch_flags, o_pop_pc, o_push_pc,
               o_stack_function, o_stack_operation, o_stall,
               o_hazard_state};
        want = '0;
        if (!i_reset) begin
            q.delete(); qr.delete();
            pend = 1'b0; isr = 1'b0;
        end else if (q.size() > 0) begin
            want = q.pop_front();
            endrti = qr.pop_front();
            if (endrti) isr = 1'b0;
            if (i_int) pend = 1'b1;
        end else begin
            if ($countones({i_call, i_ret, i_rti}) > 1) begin
                fails++;
                $display("FAIL onehot_cmd call=%0b ret=%0b rti=%0b want at most one",
                         i_call, i_ret, i_rti);
            end
            if (i_call) begin
                want = v(0, 0,1,1,1,1,0, 0,0,1,0,0);
                q.push_back(v(1, 1,0,1,1,1,0, 0,0,1,0,0)); qr.push_back(0);
                if (i_int) pend = 1'b1;
            end else if (i_rti || i_ret) begin
                want = v(0, 0,1,1,0,0,1, i_rti,1,0,0,0);
                q.push_back(v(2, 1,0,1,0,0,1, i_rti,1,0,0,0));
                qr.push_back(i_rti);
                if (i_int) pend = 1'b1;
            end else if (pend && !isr) begin
                want = v(0, 0,1,0,0,0,0, 0,0,0,0,1);
                pend = 1'b0; isr = 1'b1;
                q.push_back(v(3, 0,1,1,1,1,0, 1,0,1,0,0)); qr.push_back(0);
                q.push_back(v(4, 1,1,1,1,1,0, 0,0,1,0,0)); qr.push_back(0);
                q.push_back(v(5, 0,1,0,0,0,1, 0,1,0,1,0)); qr.push_back(0);
                q.push_back(v(2, 1,0,0,0,0,1, 0,1,0,1,0)); qr.push_back(0);
            end else if (i_int) begin
                pend = 1'b1;
            end
        end
        asserts++;
        if (got !== want) begin
            fails++;
            $display("FAIL cycle_cmp t=%0t got=%h want=%h", $time, got, want);
        end
    end

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic go(input logic c, input logic r, input logic t, input logic n);
        @(posedge i_clk);
        #1;
        i_call = c; i_ret = r; i_rti = t; i_int = n;
        @(negedge i_clk);
        #1;
        acks += int'(o_int_ack);
    endtask

    initial begin
        acks = 0;
        i_call = 1'b1;
        repeat (2) @(negedge i_clk);
        #1;
        chk("rst_state", 4'(o_state), 0);
        chk("rst_busy", 4'(o_busy), 0);
        chk("rst_push_masked", 4'(o_push_pc), 0);
        chk("rst_stall", 4'(o_stall), 0);
        @(posedge i_clk);
        #1;
        i_call = 1'b0;
        i_reset = 1'b1;

        go(1,0,0,0);
        chk("call0_push", 4'(o_push_pc), 1);
        chk("call0_hz", 4'(o_hazard_state), 0);
        chk("call0_stall", 4'(o_stall), 1);
        go(0,0,0,0);
        chk("call1_push", 4'(o_push_pc), 1);
        chk("call1_hz", 4'(o_hazard_state), 1);
        chk("call1_stall", 4'(o_stall), 0);
        go(0,0,0,0);
        chk("call2_state", 4'(o_state), 0);
        chk("call2_push", 4'(o_push_pc), 0);

        go(0,1,0,0);
        chk("ret0_bf", 4'(o_branch_flags), 0);
        go(0,0,0,0);
        chk("ret1_pop", 4'(o_pop_pc), 1);

        go(0,0,1,0);
        chk("rti0_pop", 4'(o_pop_pc), 1);
        chk("rti0_bf", 4'(o_branch_flags), 1);
        chk("rti0_hz", 4'(o_hazard_state), 0);
        go(0,0,0,0);
        chk("rti1_bf", 4'(o_branch_flags), 1);
        chk("rti1_hz", 4'(o_hazard_state), 1);

        go(1,0,0,1);
        chk("ic_call_first", 4'(o_push_pc), 1);
        chk("ic_no_ack0", 4'(o_int_ack), 0);
        go(0,0,0,0);
        chk("ic_no_ack1", 4'(o_int_ack), 0);
        go(0,0,0,0);
        chk("ic_ack", 4'(o_int_ack), 1);
        go(1,0,0,0);
        chk("int1_state", 4'(o_state), 3);
        chk("int1_bf", 4'(o_branch_flags), 1);
        go(0,0,0,0);
        chk("int2_state", 4'(o_state), 4);
        go(0,0,0,0);
        chk("intv_vsel", 4'(o_vector_sel), 1);
        chk("intv_mr", 4'(o_mem_read), 1);
        chk("intv_hz", 4'(o_hazard_state), 0);
        chk("intv_stall", 4'(o_stall), 1);
        go(0,0,0,0);
        chk("vpop2_vsel", 4'(o_vector_sel), 1);
        chk("vpop2_hz", 4'(o_hazard_state), 1);
        chk("vpop2_state", 4'(o_state), 2);
        go(0,0,0,0);
        chk("int_done_state", 4'(o_state), 0);

        acks = 0;
        go(0,0,0,1);
        go(0,0,0,0);
        go(0,0,0,1);
        go(0,0,0,0);
        go(0,0,0,1);
        go(0,0,0,0);
        chk("nest_no_ack", 4'(acks), 0);
        go(0,0,1,0);
        go(0,0,0,0);
        chk("nest_no_ack_pop2", 4'(acks), 0);
        go(0,0,0,0);
        chk("nest_ack_after_rti", 4'(o_int_ack), 1);
        repeat (6) go(0,0,0,0);
        chk("nest_one_ack", 4'(acks), 1);
        go(0,0,1,0);
        go(0,0,0,0);
        go(0,0,0,0);

        go(0,0,0,1);
        go(0,0,0,0);
        chk("rst_seq_ack", 4'(o_int_ack), 1);
        go(0,0,0,0);
        go(0,0,0,0);
        chk("rst_seq_int2", 4'(o_state), 4);
        i_reset = 1'b0;
        #1;
        chk("arst_state", 4'(o_state), 0);
        chk("arst_push", 4'(o_push_pc), 0);
        chk("arst_stall", 4'(o_stall), 0);
        chk("arst_busy", 4'(o_busy), 0);
        go(0,0,0,0);
        i_reset = 1'b1;
        go(0,0,0,0);
        chk("post_rst_no_ack", 4'(o_int_ack), 0);
        go(1,0,0,0);
        chk("post_call0_push", 4'(o_push_pc), 1);
        go(0,0,0,0);
        chk("post_call1_hz", 4'(o_hazard_state), 1);
        go(0,0,0,0);
        chk("post_idle", 4'(o_state), 0);
        go(0,0,0,0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
